ili_window_seq: RTL and testbench

Runtime-parametrised ILI9341 window sequencer. Accepts a drawing window (x0..x1, y0..y1) and emits the controller words for column address set (0x2A), page address set (0x2B) and memory write (0x2C) over a valid/ready word stream. It then forwards exactly (x1-x0+1)*(y1-y0+1) RGB565 pixels as byte pairs. It sits between the frame/pixel source and the SPI/parallel byte transmitter, replacing the fixed full-screen loop command table.

---
 rtl/ili_window_seq_pkg.sv | 36 +++
 rtl/ili_window_seq_if.sv | 16 +
 rtl/ili_window_area.sv | 24 ++
 rtl/ili_window_seq.sv | 171 +++++++++++++++++
 tb/tb_ili_window_seq.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ili_window_seq_pkg.sv
// Shared constants, state encoding and word-packing helpers for the ILI9341 window sequencer.
package pkg_ili_window;

  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CASET,
    S_PASET,
    S_RAMWR,
    S_PIX_HI,
    S_PIX_LO,
    S_DONE
  } state_t;

  function automatic logic [9:0] pack_word(input logic csx, input logic dcx, input logic [7:0] b);
    return {csx, dcx, b};
  endfunction

  // Parameter bytes of an address-set command: idx 1..4 = a_hi, a_lo, b_hi, b_lo.
  function automatic logic [7:0] hdr_byte(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] idx);
    case (idx)
      3'd1:    return a[15:8];
      3'd2:    return a[7:0];
      3'd3:    return b[15:8];
      default: return b[7:0];
    endcase
  endfunction

endpackage

// File: rtl/ili_window_seq_if.sv
// Command word stream towards the byte transmitter and pixel stream from the frame source.
// Valid/ready: a transfer happens on a rising edge where valid && ready; once valid is high the
// producer holds its payload stable and keeps valid high until that transfer.
interface ili_window_seq_if;
  logic [9:0]  cmd_word;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;

  modport master (output cmd_word, cmd_valid, pix_ready,
                  input  cmd_ready, pix_data, pix_valid);
  modport slave  (input  cmd_word, cmd_valid, pix_ready,
                  output cmd_ready, pix_data, pix_valid);
endinterface

// File: rtl/ili_window_area.sv
// Registered pixel count of an inclusive window, one cycle after the corners settle.
module ili_window_area #(
  parameter int COORD_W = 9,
  parameter int TOT_W   = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] y1,
  output logic [TOT_W-1:0]   total
);
  logic [TOT_W-1:0] w;
  logic [TOT_W-1:0] h;

  assign w = TOT_W'(x1) - TOT_W'(x0) + TOT_W'(1);
  assign h = TOT_W'(y1) - TOT_W'(y0) + TOT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) total <= '0;
    else     total <= w * h;
  end
endmodule

// File: rtl/ili_window_seq.sv
// ILI9341 window sequencer: emits CASET/PASET/RAMWR headers then streams RGB565 pixels as byte pairs.
module ili_window_seq
  import pkg_ili_window::*;
#(
  parameter int SCREEN_W       = 240,
  parameter int SCREEN_H       = 320,
  parameter int COORD_W        = 9,
  parameter int SKIP_UNCHANGED = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] y1,
  output logic               busy,
  output logic               done,
  output logic               err,
  output state_t             dbg_state,
  ili_window_seq_if.master   bus
);
  localparam int TOT_W = $clog2(SCREEN_W * SCREEN_H + 1);
  localparam logic [COORD_W:0] X_LIM = (COORD_W+1)'(SCREEN_W);
  localparam logic [COORD_W:0] Y_LIM = (COORD_W+1)'(SCREEN_H);

  state_t             state;
  logic [2:0]         sub;
  logic [COORD_W-1:0] cx0, cx1, cy0, cy1;
  logic [COORD_W-1:0] lx0, lx1, ly0, ly1;
  logic               last_valid;
  logic [TOT_W-1:0]   total;
  logic [TOT_W-1:0]   remaining;
  logic [9:0]         word;
  logic               valid;
  logic [15:0]        cx0_w, cx1_w, cy0_w, cy1_w;
  logic               win_ok, skip_hit, hs;

  assign cx0_w = 16'(cx0);
  assign cx1_w = 16'(cx1);
  assign cy0_w = 16'(cy0);
  assign cy1_w = 16'(cy1);

  assign win_ok   = (x0 <= x1) && (y0 <= y1) && ({1'b0, x1} < X_LIM) && ({1'b0, y1} < Y_LIM);
  assign skip_hit = (SKIP_UNCHANGED != 0) && last_valid &&
                    (x0 == lx0) && (x1 == lx1) && (y0 == ly0) && (y1 == ly1);
  assign hs       = valid && bus.cmd_ready;

  assign bus.cmd_word  = word;
  assign bus.cmd_valid = valid;
  assign bus.pix_ready = (state == S_PIX_LO) && hs;
  assign dbg_state     = state;

  ili_window_area #(.COORD_W(COORD_W), .TOT_W(TOT_W)) u_area (
    .clk   (clk),
    .rst   (rst),
    .x0    (cx0),
    .x1    (cx1),
    .y0    (cy0),
    .y1    (cy1),
    .total (total)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      sub        <= 3'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      valid      <= 1'b0;
      word       <= '0;
      remaining  <= '0;
      last_valid <= 1'b0;
      {cx0, cx1, cy0, cy1} <= '0;
      {lx0, lx1, ly0, ly1} <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !win_ok) begin
            err <= 1'b1;
          end else if (start) begin
            cx0  <= x0;
            cx1  <= x1;
            cy0  <= y0;
            cy1  <= y1;
            busy <= 1'b1;
            sub  <= 3'd0;
            if (skip_hit) begin
              // The area register only reflects the new corners one cycle from now.
              state <= S_RAMWR;
              valid <= 1'b0;
            end else begin
              state <= S_CASET;
              word  <= pack_word(LOW, LOW, CMD_CASET);
              valid <= 1'b1;
            end
          end
        end
        S_CASET: if (hs) begin
          if (sub == 3'd4) begin
            state <= S_PASET;
            sub   <= 3'd0;
            word  <= pack_word(LOW, LOW, CMD_PASET);
          end else begin
            sub  <= sub + 3'd1;
            word <= pack_word(LOW, HIGH, hdr_byte(cx0_w, cx1_w, sub + 3'd1));
          end
        end
        S_PASET: if (hs) begin
          if (sub == 3'd4) begin
            state <= S_RAMWR;
            sub   <= 3'd0;
            word  <= pack_word(LOW, LOW, CMD_RAMWR);
          end else begin
            sub  <= sub + 3'd1;
            word <= pack_word(LOW, HIGH, hdr_byte(cy0_w, cy1_w, sub + 3'd1));
          end
        end
        S_RAMWR: begin
          if (!valid) begin
            word  <= pack_word(LOW, LOW, CMD_RAMWR);
            valid <= 1'b1;
          end else if (bus.cmd_ready) begin
            state     <= S_PIX_HI;
            remaining <= total;
            word      <= pack_word(LOW, HIGH, bus.pix_data[15:8]);
            valid     <= bus.pix_valid;
          end
        end
        S_PIX_HI: begin
          if (!valid) begin
            word  <= pack_word(LOW, HIGH, bus.pix_data[15:8]);
            valid <= bus.pix_valid;
          end else if (bus.cmd_ready) begin
            state <= S_PIX_LO;
            word  <= pack_word(LOW, HIGH, bus.pix_data[7:0]);
            valid <= bus.pix_valid;
          end
        end
        S_PIX_LO: begin
          if (!valid) begin
            word  <= pack_word(LOW, HIGH, bus.pix_data[7:0]);
            valid <= bus.pix_valid;
          end else if (bus.cmd_ready) begin
            remaining <= remaining - TOT_W'(1);
            valid     <= 1'b0;
            if (remaining == TOT_W'(1)) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= S_PIX_HI;
            end
          end
        end
        S_DONE: begin
          lx0        <= cx0;
          lx1        <= cx1;
          ly0        <= cy0;
          ly1        <= cy1;
          last_valid <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ili_window_seq.sv
// Self-checking bench for ili_window_seq: start-check table, model-checked random windows, reset corners.
module tb_ili_window_seq;
  import pkg_ili_window::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [8:0] x0, x1, y0, y1;
  logic       busy, done, err;
  state_t     dbg_state;

  ili_window_seq_if bus ();

  ili_window_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x0        (x0),
    .x1        (x1),
    .y0        (y0),
    .y1        (y1),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [9:0]  exp_q[$];
  logic [9:0]  got_q[$];
  logic [15:0] pix_src_q[$];
  int          pr_cnt, pr_total, done_cnt, stab_err;
  bit          stall_mode = 1'b0;
  bit          model_last_valid = 1'b0;
  logic [8:0]  ml_x0, ml_x1, ml_y0, ml_y1;

  typedef struct {
    logic [8:0] x0, x1, y0, y1;
    bit         exp_err;
    logic [9:0] exp_first;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, so it sees what the next rising edge will transfer.
  initial begin
    bit         prev_stall;
    logic [9:0] prev_word;
    prev_stall = 1'b0;
    prev_word  = '0;
    pr_total   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && (!bus.cmd_valid || bus.cmd_word !== prev_word)) stab_err++;
        if (bus.cmd_valid && bus.cmd_ready) got_q.push_back(bus.cmd_word);
        if (bus.pix_ready) begin
          pr_cnt++;
          pr_total++;
        end
        if (done) done_cnt++;
        prev_stall = bus.cmd_valid && !bus.cmd_ready;
        prev_word  = bus.cmd_word;
      end
    end
  end

  // Downstream ready and pixel source; a pixel is retired after the edge that saw pix_ready.
  initial begin
    int pops;
    pops          = 0;
    bus.cmd_ready = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      while (pops < pr_total) begin
        pops++;
        if (pix_src_q.size() > 0) void'(pix_src_q.pop_front());
      end
      bus.cmd_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pix_src_q.size() > 0) bus.pix_data = pix_src_q[0];
      bus.pix_valid = (pix_src_q.size() > 0) && (!stall_mode || $urandom_range(0, 3) != 0);
    end
  end

  task automatic push_hdr(input logic [7:0] cmd, input logic [8:0] a, input logic [8:0] b);
    logic [15:0] a16, b16;
    a16 = {7'd0, a};
    b16 = {7'd0, b};
    exp_q.push_back({2'b00, cmd});
    exp_q.push_back({2'b01, a16[15:8]});
    exp_q.push_back({2'b01, a16[7:0]});
    exp_q.push_back({2'b01, b16[15:8]});
    exp_q.push_back({2'b01, b16[7:0]});
  endtask

  task automatic drive_start(input logic [8:0] a0, input logic [8:0] a1,
                             input logic [8:0] b0, input logic [8:0] b1);
    @(posedge clk);
    #1;
    start = 1'b1;
    x0 = a0; x1 = a1; y0 = b0; y1 = b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      busy,          1'b0);
    check({tag, "_done"},      done,          1'b0);
    check({tag, "_err"},       err,           1'b0);
    check({tag, "_cmd_valid"}, bus.cmd_valid, 1'b0);
    check({tag, "_cmd_word"},  bus.cmd_word,  10'h000);
    check({tag, "_pix_ready"}, bus.pix_ready, 1'b0);
  endtask

  task automatic apply_reset(input string tag);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pix_src_q.delete();
    model_last_valid = 1'b0;
  endtask

  task automatic run_window(input logic [8:0] a0, input logic [8:0] a1,
                            input logic [8:0] b0, input logic [8:0] b1,
                            input bit stall, input bit poke, output logic [9:0] first);
    bit hdr;
    int n, mism, c;
    hdr = !(model_last_valid && a0 == ml_x0 && a1 == ml_x1 && b0 == ml_y0 && b1 == ml_y1);
    n = (int'(a1) - int'(a0) + 1) * (int'(b1) - int'(b0) + 1);
    if (pix_src_q.size() == 0)
      for (int i = 0; i < n; i++) pix_src_q.push_back(16'($urandom));
    exp_q.delete();
    if (hdr) begin
      push_hdr(CMD_CASET, a0, a1);
      push_hdr(CMD_PASET, b0, b1);
    end
    exp_q.push_back({2'b00, CMD_RAMWR});
    foreach (pix_src_q[i]) begin
      exp_q.push_back({2'b01, pix_src_q[i][15:8]});
      exp_q.push_back({2'b01, pix_src_q[i][7:0]});
    end
    got_q.delete();
    pr_cnt = 0; done_cnt = 0; stab_err = 0;
    stall_mode = stall;
    drive_start(a0, a1, b0, b1);
    @(negedge clk);
    check("busy_after_start", busy, 1'b1);
    if (hdr) check("first_word_next_cycle", {bus.cmd_valid, bus.cmd_word}, {1'b1, 10'h02A});
    if (poke) begin
      drive_start(9'd5, 9'd4, 9'd0, 9'd0);
      @(negedge clk);
      check("start_while_busy_no_err", err, 1'b0);
    end
    c = 0;
    while (c < 4000 && done_cnt == 0) begin
      @(negedge clk);
      c++;
    end
    check("done_seen", done_cnt > 0, 1'b1);
    check("busy_falls_with_done", busy, 1'b0);
    repeat (3) @(negedge clk);
    check("single_done", done_cnt, 1);
    check("word_count", got_q.size(), exp_q.size());
    mism = 0;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) mism++;
    check("word_stream", mism, 0);
    check("pix_ready_pulses", pr_cnt, n);
    check("stable_while_stalled", stab_err, 0);
    first = (got_q.size() > 0) ? got_q[0] : 10'h3FF;
    model_last_valid = 1'b1;
    ml_x0 = a0; ml_x1 = a1; ml_y0 = b0; ml_y1 = b1;
    stall_mode = 1'b0;
  endtask

  initial begin
    logic [9:0] first;
    logic [9:0] fs_hdr[11];
    int mism, c;

    vecs[0] = '{9'd5,   9'd4,   9'd0,   9'd0,   1'b1, 10'h000};
    vecs[1] = '{9'd0,   9'd240, 9'd0,   9'd0,   1'b1, 10'h000};
    vecs[2] = '{9'd0,   9'd0,   9'd9,   9'd8,   1'b1, 10'h000};
    vecs[3] = '{9'd0,   9'd0,   9'd0,   9'd320, 1'b1, 10'h000};
    vecs[4] = '{9'd0,   9'd0,   9'd0,   9'd0,   1'b0, 10'h02A};
    vecs[5] = '{9'd0,   9'd0,   9'd0,   9'd0,   1'b0, 10'h02C};
    vecs[6] = '{9'd239, 9'd239, 9'd319, 9'd319, 1'b0, 10'h02A};
    vecs[7] = '{9'd239, 9'd239, 9'd300, 9'd319, 1'b0, 10'h02A};
    vecs[8] = '{9'd0,   9'd239, 9'd0,   9'd320, 1'b1, 10'h000};
    vecs[9] = '{9'd239, 9'd239, 9'd300, 9'd319, 1'b0, 10'h02C};
    fs_hdr = '{10'h02A, 10'h100, 10'h100, 10'h100, 10'h1EF,
               10'h02B, 10'h100, 10'h100, 10'h101, 10'h13F, 10'h02C};

    rst = 1'b1; start = 1'b0; x0 = '0; x1 = '0; y0 = '0; y1 = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].exp_err) begin
        drive_start(vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1);
        @(negedge clk);
        check("reject_err", err, 1'b1);
        check("reject_busy", busy, 1'b0);
        check("reject_cmd_valid", bus.cmd_valid, 1'b0);
        @(negedge clk);
        check("reject_err_one_cycle", err, 1'b0);
        check("reject_still_idle", bus.cmd_valid, 1'b0);
      end else begin
        run_window(vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1, 1'b0, 1'b0, first);
        check("table_first_word", first, vecs[i].exp_first);
      end
    end

    pix_src_q.push_back(16'hF800);
    pix_src_q.push_back(16'h07E0);
    run_window(9'd10, 9'd11, 9'd20, 9'd20, 1'b0, 1'b1, first);
    check("two_px_first", first, 10'h02A);
    check("two_px_b0", got_q[11], 10'h1F8);
    check("two_px_b1", got_q[12], 10'h100);
    check("two_px_b2", got_q[13], 10'h107);
    check("two_px_b3", got_q[14], 10'h1E0);

    run_window(9'd10, 9'd11, 9'd20, 9'd20, 1'b0, 1'b0, first);
    check("repeat_skips_header", first, 10'h02C);
    check("repeat_len", got_q.size(), 5);

    run_window(9'd10, 9'd11, 9'd20, 9'd21, 1'b0, 1'b0, first);
    check("y1_change_header", first, 10'h02A);
    check("y1_change_len", got_q.size(), 11 + 8);

    run_window(9'd50, 9'd52, 9'd60, 9'd62, 1'b1, 1'b0, first);
    check("stall_first", first, 10'h02A);

    // Full-screen header, reset during PASET.
    for (int i = 0; i < 16; i++) pix_src_q.push_back(16'($urandom));
    got_q.delete();
    drive_start(9'd0, 9'd239, 9'd0, 9'd319);
    c = 0;
    while (c < 200 && got_q.size() < 7) begin
      @(negedge clk);
      c++;
    end
    check("mid_paset_reached", got_q.size() >= 7, 1'b1);
    mism = 0;
    for (int i = 0; i < 7; i++) if (got_q[i] !== fs_hdr[i]) mism++;
    check("fullscreen_caset_words", mism, 0);
    apply_reset("rst_mid_paset");

    // Full-screen again: complete header, reset once pixels are flowing.
    for (int i = 0; i < 16; i++) pix_src_q.push_back(16'($urandom));
    got_q.delete();
    drive_start(9'd0, 9'd239, 9'd0, 9'd319);
    c = 0;
    while (c < 200 && got_q.size() < 19) begin
      @(negedge clk);
      c++;
    end
    check("mid_pixel_reached", got_q.size() >= 19, 1'b1);
    mism = 0;
    for (int i = 0; i < 11; i++) if (got_q[i] !== fs_hdr[i]) mism++;
    check("fullscreen_header_words", mism, 0);
    apply_reset("rst_mid_pixel");

    run_window(9'd50, 9'd52, 9'd60, 9'd62, 1'b0, 1'b0, first);
    check("after_reset_full_header", first, 10'h02A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
